// File: rtl/asip_wb_pkg.sv
// Shared types for the vector ASIP memory/writeback stage.
package asip_wb_pkg;

  typedef enum logic [1:0] {
    WB_MEM   = 2'd0,
    WB_ALU   = 2'd1,
    WB_IMM   = 2'd2,
    WB_LANE0 = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } wb_state_e;

endpackage

// File: rtl/stage_writeback_vec_lane_extender.sv
// Widens one memory lane to register width, sign- or zero-extending.
module lane_extender #(
  parameter int MEM_W  = 8,
  parameter int DATA_W = 16
) (
  input  logic                     sign_ext,
  input  logic signed [MEM_W-1:0]  din,
  output logic signed [DATA_W-1:0] dout
);

  generate
    if (MEM_W == DATA_W) begin : g_pass
      logic unused_sign;
      assign unused_sign = sign_ext;
      assign dout = din;
    end else begin : g_ext
      always_comb dout = sign_ext ? DATA_W'(din) : DATA_W'($unsigned(din));
    end
  endgenerate

endmodule

// File: rtl/stage_writeback_vec.sv
// Memory/writeback stage: issues vector loads/stores over req/gnt/rvalid and drives the RF write port.
module stage_writeback_vec
  import asip_wb_pkg::*;
#(
  parameter int VEC_SIZE = 4,
  parameter int DATA_W   = 16,
  parameter int MEM_W    = 8,
  parameter int ADDR_W   = 16,
  parameter int RIDX_W   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         mem_rd,
  input  logic                         mem_wr,
  input  logic [1:0]                   wb_sel,
  input  logic                         reg_we,
  input  logic                         sign_ext,
  input  logic [VEC_SIZE-1:0]          lane_mask,
  input  logic [RIDX_W-1:0]            rd_idx,
  input  logic [DATA_W-1:0]            imm,
  input  logic [VEC_SIZE*DATA_W-1:0]   alu_result,
  input  logic [VEC_SIZE*DATA_W-1:0]   alu_op1,
  input  logic [VEC_SIZE*DATA_W-1:0]   alu_op2,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [VEC_SIZE*MEM_W-1:0]    mem_wdata,
  output logic [VEC_SIZE-1:0]          mem_be,
  input  logic                         mem_gnt,
  input  logic                         mem_rvalid,
  input  logic [VEC_SIZE*MEM_W-1:0]    mem_rdata,
  output logic                         wb_valid,
  output logic [VEC_SIZE-1:0]          wb_we,
  output logic [RIDX_W-1:0]            wb_idx,
  output logic [VEC_SIZE*DATA_W-1:0]   wb_data
);

  localparam int LW = VEC_SIZE * DATA_W;
  localparam int MW = VEC_SIZE * MEM_W;

  wb_state_e             state, state_nxt;
  logic                  xfer, mem_op;
  logic [MW-1:0]         wdata_in;
  logic [LW-1:0]         ext_data;
  logic                  unused_bits;

  wb_sel_e               sel_p1;
  logic                  we_p1, sign_p1;
  logic [VEC_SIZE-1:0]   mask_p1;
  logic [RIDX_W-1:0]     idx_p1;
  logic [DATA_W-1:0]     imm_p1;
  logic [LW-1:0]         alu_p1;

  assign xfer   = in_valid & in_ready;
  assign mem_op = mem_rd | mem_wr;
  assign unused_bits = ^{alu_op1, alu_op2};

  function automatic logic [LW-1:0] sel_wb(input wb_sel_e sel, input logic [LW-1:0] memv,
                                           input logic [LW-1:0] alu, input logic [DATA_W-1:0] immv);
    logic [LW-1:0] r;
    case (sel)
      WB_MEM:   r = memv;
      WB_ALU:   r = alu;
      WB_IMM:   r = {VEC_SIZE{immv}};
      WB_LANE0: r = {VEC_SIZE{alu[DATA_W-1:0]}};
      default:  r = '0;
    endcase
    return r;
  endfunction

  for (genvar g = 0; g < VEC_SIZE; g++) begin : g_lane
    assign wdata_in[g*MEM_W +: MEM_W] = alu_op1[g*DATA_W +: MEM_W];
    lane_extender #(.MEM_W(MEM_W), .DATA_W(DATA_W)) u_ext (
      .sign_ext (sign_p1),
      .din      (mem_rdata[g*MEM_W +: MEM_W]),
      .dout     (ext_data[g*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && mem_op) state_nxt = REQ;
      REQ:     if (mem_gnt)        state_nxt = mem_we ? IDLE : WAIT;
      WAIT:    if (mem_rvalid)     state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  // p1: request fields and the captured instruction; writeback beat registered from p1 or directly from EX
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= '0;
      wb_idx    <= '0;
      wb_data   <= '0;
      sel_p1    <= WB_MEM;
      we_p1     <= 1'b0;
      sign_p1   <= 1'b0;
      mask_p1   <= '0;
      idx_p1    <= '0;
      imm_p1    <= '0;
      alu_p1    <= '0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= '0;
      case (state)
        IDLE: if (xfer) begin
          if (mem_op) begin
            mem_req   <= 1'b1;
            mem_we    <= mem_wr;
            mem_addr  <= mem_wr ? alu_op2[ADDR_W-1:0] : imm[ADDR_W-1:0];
            mem_wdata <= wdata_in;
            mem_be    <= lane_mask;
            sel_p1    <= wb_sel_e'(wb_sel);
            we_p1     <= reg_we;
            sign_p1   <= sign_ext;
            mask_p1   <= lane_mask;
            idx_p1    <= rd_idx;
            imm_p1    <= imm;
            alu_p1    <= alu_result;
          end else begin
            wb_valid <= 1'b1;
            wb_we    <= reg_we ? lane_mask : '0;
            wb_idx   <= rd_idx;
            wb_data  <= sel_wb(wb_sel_e'(wb_sel), '0, alu_result, imm);
          end
        end
        REQ: if (mem_gnt) begin
          mem_req <= 1'b0;
          if (mem_we) begin
            wb_valid <= 1'b1;
            wb_idx   <= idx_p1;
            wb_data  <= sel_wb(sel_p1, '0, alu_p1, imm_p1);
          end
        end
        WAIT: if (mem_rvalid) begin
          wb_valid <= 1'b1;
          wb_we    <= we_p1 ? mask_p1 : '0;
          wb_idx   <= idx_p1;
          wb_data  <= sel_wb(sel_p1, ext_data, alu_p1, imm_p1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_writeback_vec.sv
// Randomized and directed bench for stage_writeback_vec with a lane-level reference model.
module tb_stage_writeback_vec;

  localparam int VS = 4, DW = 16, MW = 8, AW = 16, RW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, in_valid, in_ready, mem_rd, mem_wr, reg_we, sign_ext;
  logic [1:0]        wb_sel;
  logic [VS-1:0]     lane_mask, mem_be, wb_we;
  logic [RW-1:0]     rd_idx, wb_idx;
  logic [DW-1:0]     imm;
  logic [VS*DW-1:0]  alu_result, alu_op1, alu_op2, wb_data;
  logic              mem_req, mem_we, mem_gnt, mem_rvalid, wb_valid;
  logic [AW-1:0]     mem_addr;
  logic [VS*MW-1:0]  mem_wdata, mem_rdata;

  stage_writeback_vec #(.VEC_SIZE(VS), .DATA_W(DW), .MEM_W(MW), .ADDR_W(AW), .RIDX_W(RW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_sel(wb_sel), .reg_we(reg_we), .sign_ext(sign_ext),
    .lane_mask(lane_mask), .rd_idx(rd_idx), .imm(imm), .alu_result(alu_result),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_idx(wb_idx), .wb_data(wb_data)
  );

  int passed = 0, total = 0;

  typedef struct {
    logic [VS-1:0]    we;
    logic [RW-1:0]    idx;
    logic [VS*DW-1:0] data;
  } beat_t;
  beat_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // kind: 0 = ALU-only, 1 = load, 2 = store
  function automatic logic [VS*DW-1:0] model_data(input int kind, input logic [1:0] sel, input logic sx,
      input logic [VS*DW-1:0] alu, input logic [DW-1:0] im, input logic [VS*MW-1:0] rdata);
    logic [VS*DW-1:0] r;
    for (int i = 0; i < VS; i++) begin
      int v;
      case (sel)
        2'd0: begin
          v = (kind == 1) ? int'(rdata[i*MW +: MW]) : 0;
          if (kind == 1 && sx && v >= (1 << (MW-1))) v = v - (1 << MW) + (1 << DW);
        end
        2'd1:    v = int'(alu[i*DW +: DW]);
        2'd2:    v = int'(im);
        default: v = int'(alu[DW-1:0]);
      endcase
      r[i*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [VS*MW-1:0] model_wdata(input logic [VS*DW-1:0] op1);
    logic [VS*MW-1:0] r;
    for (int i = 0; i < VS; i++) r[i*MW +: MW] = op1[i*DW +: MW];
    return r;
  endfunction

  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && wb_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_beat: wb_valid=1 with nothing pending, required 0");
        end else begin
          b = exp_q.pop_front();
          chk("wb_we", 64'(wb_we), 64'(b.we));
          chk("wb_idx", 64'(wb_idx), 64'(b.idx));
          chk("wb_data", wb_data, b.data);
        end
      end
    end
  end

  task automatic scramble();
    wb_sel = 2'($urandom); reg_we = 1'($urandom); sign_ext = 1'($urandom);
    lane_mask = 4'($urandom); rd_idx = 4'($urandom); imm = 16'($urandom);
    alu_result = {$urandom, $urandom}; alu_op1 = {$urandom, $urandom}; alu_op2 = {$urandom, $urandom};
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  // Called just after a rising edge; returns at the falling edge of the writeback beat cycle.
  task automatic do_instr(input int kind, input logic [1:0] sel, input logic rwe, input logic sx,
      input logic [VS-1:0] mask, input logic [RW-1:0] idx, input logic [DW-1:0] im,
      input logic [VS*DW-1:0] alu, input logic [VS*DW-1:0] op1, input logic [VS*DW-1:0] op2,
      input int gnt_dly, input int rv_dly, input logic [VS*MW-1:0] rdata, input logic spur);
    beat_t b;
    logic [AW-1:0] exp_addr;
    in_valid = 1'b1; mem_rd = (kind == 1); mem_wr = (kind == 2); wb_sel = sel; reg_we = rwe;
    sign_ext = sx; lane_mask = mask; rd_idx = idx; imm = im; alu_result = alu; alu_op1 = op1; alu_op2 = op2;
    b.we = (kind == 2 || !rwe) ? '0 : mask;
    b.idx = idx;
    b.data = model_data(kind, sel, sx, alu, im, rdata);
    exp_q.push_back(b);
    exp_addr = (kind == 2) ? op2[AW-1:0] : im[AW-1:0];
    @(negedge clk); chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    if (kind != 0) begin
      for (int k = 0; k <= gnt_dly; k++) begin
        mem_gnt = (k == gnt_dly);
        mem_rvalid = (k == gnt_dly) && spur && (kind == 1);
        mem_rdata = 32'($urandom);
        @(negedge clk);
        chk("mem_req", 64'(mem_req), 64'd1);
        chk("mem_we", 64'(mem_we), 64'(kind == 2));
        chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
        chk("mem_be", 64'(mem_be), 64'(mask));
        if (kind == 2) chk("mem_wdata", 64'(mem_wdata), 64'(model_wdata(op1)));
        chk("in_ready_req", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (kind == 1) begin
        for (int k = 1; k <= rv_dly; k++) begin
          if (k == rv_dly) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
          @(negedge clk);
          chk("in_ready_wait", 64'(in_ready), 64'd0);
          chk("mem_req_wait", 64'(mem_req), 64'd0);
          @(posedge clk); #1;
        end
        mem_rvalid = 1'b0;
      end
    end
    @(negedge clk); chk("wb_valid_latency", 64'(wb_valid), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_mem_be"}, 64'(mem_be), 64'd0);
    chk({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    chk({tag, "_wb_we"}, 64'(wb_we), 64'd0);
    chk({tag, "_wb_idx"}, 64'(wb_idx), 64'd0);
    chk({tag, "_wb_data"}, wb_data, 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    scramble();
    repeat (3) @(posedge clk);
    #1 check_reset_values("rst");
    reset = 1'b1;

    // single ALU op
    @(posedge clk); #1;
    do_instr(0, 2'd1, 1'b1, 1'b0, 4'b1111, 4'd3, 16'h0, 64'h0004_0003_0002_0001, '0, '0, 0, 0, '0, 1'b0);
    chk("alu_data_lit", wb_data, 64'h0004_0003_0002_0001);
    chk("alu_we_lit", 64'(wb_we), 64'hF);

    // five back-to-back ALU ops
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      beat_t b;
      in_valid = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; wb_sel = 2'd1; reg_we = 1'b1;
      lane_mask = 4'($urandom); rd_idx = 4'(i); alu_result = {$urandom, $urandom};
      b.we = lane_mask; b.idx = rd_idx; b.data = alu_result;
      exp_q.push_back(b);
      @(negedge clk);
      chk("b2b_in_ready", 64'(in_ready), 64'd1);
      if (i > 0) chk("b2b_wb_valid", 64'(wb_valid), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk); chk("b2b_last_valid", 64'(wb_valid), 64'd1);

    // store with grant in the third request cycle
    @(posedge clk); #1;
    do_instr(2, 2'd1, 1'b1, 1'b0, 4'b0101, 4'd7, 16'h5555, 64'h1111_2222_3333_4444,
             64'h0123_01EF_01CD_01AB, 64'h0000_0000_0000_0040, 2, 0, '0, 1'b0);
    chk("st_we_lit", 64'(wb_we), 64'd0);

    // loads, sign- then zero-extended, rvalid two cycles after grant
    @(posedge clk); #1;
    do_instr(1, 2'd0, 1'b1, 1'b1, 4'b1111, 4'd9, 16'h0010, '0, '0, '0, 1, 2, 32'h0102_7F80, 1'b1);
    chk("ld_sx_lane0", 64'(wb_data[15:0]), 64'hFF80);
    chk("ld_sx_lane1", 64'(wb_data[31:16]), 64'h007F);
    @(posedge clk); #1;
    do_instr(1, 2'd0, 1'b1, 1'b0, 4'b1111, 4'd9, 16'h0010, '0, '0, '0, 1, 2, 32'h0102_7F80, 1'b0);
    chk("ld_zx_lane0", 64'(wb_data[15:0]), 64'h0080);

    // broadcasts
    @(posedge clk); #1;
    do_instr(0, 2'd2, 1'b1, 1'b0, 4'b1111, 4'd1, 16'h1234, {$urandom, $urandom}, '0, '0, 0, 0, '0, 1'b0);
    chk("imm_bcast_lit", wb_data, 64'h1234_1234_1234_1234);
    @(posedge clk); #1;
    do_instr(0, 2'd3, 1'b1, 1'b0, 4'b1111, 4'd2, 16'h0, 64'h1111_2222_3333_BEEF, '0, '0, 0, 0, '0, 1'b0);
    chk("lane0_bcast_lit", wb_data, 64'hBEEF_BEEF_BEEF_BEEF);

    // reset while a load waits for data; a late rvalid must not produce a beat
    @(posedge clk); #1;
    in_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; wb_sel = 2'd0; reg_we = 1'b1; lane_mask = 4'hF;
    imm = 16'h0020; rd_idx = 4'd5;
    @(posedge clk); #1;
    in_valid = 1'b0; mem_rd = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_values("midrst");
    @(posedge clk); #1;
    reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk); chk("late_rvalid_no_beat", 64'(wb_valid), 64'd0);
    @(posedge clk); #1;
    do_instr(0, 2'd1, 1'b1, 1'b0, 4'b0011, 4'd4, 16'h0, 64'hAAAA_BBBB_CCCC_DDDD, '0, '0, 0, 0, '0, 1'b0);

    // randomized instruction mix
    for (int n = 0; n < 80; n++) begin
      @(posedge clk); #1;
      do_instr(int'($urandom_range(0, 2)), 2'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
               4'($urandom), 16'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
               {$urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
               32'($urandom), 1'($urandom));
    end

    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL pending_beats: %0d outstanding, required 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
